// File: rtl/clk_wiz_pkg.sv
// Shared definitions for the behavioural clock wizard.
//   - Default divide ratios and lock delay used by clk_wiz2.
//   - cnt_w(n): counter width able to hold the values 0..n-1.
package clk_wiz_pkg;

    localparam int DIV0_DEFAULT        = 2;
    localparam int DIV1_DEFAULT        = 4;
    localparam int LOCK_CYCLES_DEFAULT = 64;

    function automatic int cnt_w(input int n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/clk_div_ch.sv
// One divided-clock channel.
//   clkin1 : reference clock
//   rst_n  : asynchronous active-low reset (already synchronised on release)
//   en     : run enable; the counter is held at 0 while low
//   clkout : clkin1 / DIV, driven straight from a flop
// High phase is DIV/2 cycles; odd DIV makes the low phase one cycle longer.
module clk_div_ch
    import clk_wiz_pkg::*;
#(
    parameter int DIV = DIV0_DEFAULT
) (
    input  logic clkin1,
    input  logic rst_n,
    input  logic en,
    output logic clkout
);

    localparam int           W    = cnt_w(DIV);
    localparam logic [W-1:0] LAST = W'(DIV - 1);
    localparam logic [W-1:0] HALF = W'(DIV / 2);

    generate
        if (DIV < 2) begin : g_bad_div
            $error("clk_div_ch: DIV must be >= 2");
        end
    endgenerate

    logic [W-1:0] cnt;

    always_ff @(posedge clkin1 or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            clkout <= 1'b0;
        end else if (en) begin
            clkout <= (cnt < HALF);
            cnt    <= (cnt == LAST) ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/clk_wiz2.sv
// Behavioural stand-in for the vendor PLL on the 50 MHz board clock.
//   clkin1   : reference clock, the only clock of the block
//   rst_n    : asynchronous active-low reset
//   clkout0  : clkin1 / DIV0, registered
//   clkout1  : clkin1 / DIV1, registered
//   pll_lock : sticky "clocks valid", set LOCK_CYCLES edges after the
//              synchronised reset release
// CLKIN_FREQ (MHz) is informational only.
module clk_wiz2
    import clk_wiz_pkg::*;
#(
    parameter real CLKIN_FREQ  = 50.0,
    parameter int  DIV0        = DIV0_DEFAULT,
    parameter int  DIV1        = DIV1_DEFAULT,
    parameter int  LOCK_CYCLES = LOCK_CYCLES_DEFAULT
) (
    input  logic clkin1,
    input  logic rst_n,
    output logic clkout0,
    output logic clkout1,
    output logic pll_lock
);

    localparam int            LW        = $clog2(LOCK_CYCLES + 1);
    localparam logic [LW-1:0] LOCK_LAST = LW'(LOCK_CYCLES - 1);
    localparam logic [LW-1:0] LOCK_SAT  = LW'(LOCK_CYCLES);

    generate
        if (DIV0 < 2) begin : g_bad_div0
            $error("clk_wiz2: DIV0 must be >= 2");
        end
        if (DIV1 < 2) begin : g_bad_div1
            $error("clk_wiz2: DIV1 must be >= 2");
        end
        if (LOCK_CYCLES < 1) begin : g_bad_lock
            $error("clk_wiz2: LOCK_CYCLES must be >= 1");
        end
        if (CLKIN_FREQ <= 0.0) begin : g_bad_freq
            $error("clk_wiz2: CLKIN_FREQ must be positive");
        end
    endgenerate

    // Reset asserts immediately, releases two clkin1 edges later.
    logic [1:0] rst_sync_q;
    logic       rst_sync;

    always_ff @(posedge clkin1 or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync_q <= '0;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_sync = rst_sync_q[1];

    // Lock counter runs only until lock, then parks at LOCK_CYCLES so
    // pll_lock can only be cleared by reset.
    logic [LW-1:0] lock_cnt;

    always_ff @(posedge clkin1 or negedge rst_sync) begin
        if (!rst_sync) begin
            lock_cnt <= '0;
            pll_lock <= 1'b0;
        end else if (!pll_lock) begin
            if (lock_cnt == LOCK_LAST) begin
                lock_cnt <= LOCK_SAT;
                pll_lock <= 1'b1;
            end else begin
                lock_cnt <= lock_cnt + 1'b1;
            end
        end
    end

    // Both channels share the same enable so they leave reset in phase.
    clk_div_ch #(
        .DIV (DIV0)
    ) u_ch0 (
        .clkin1 (clkin1),
        .rst_n  (rst_sync),
        .en     (pll_lock),
        .clkout (clkout0)
    );

    clk_div_ch #(
        .DIV (DIV1)
    ) u_ch1 (
        .clkin1 (clkin1),
        .rst_n  (rst_sync),
        .en     (pll_lock),
        .clkout (clkout1)
    );

endmodule

// File: tb/tb_clk_wiz2.sv
// Directed bench for clk_wiz2: a default instance (DIV0=2, DIV1=4) and an
// odd-divisor instance (DIV0=3, DIV1=6) driven by the same clock and reset.
`timescale 1ns/1ps
module tb_clk_wiz2;

    logic clk_tb;
    logic rst_n;

    logic c0, c1, lock_a;
    logic b0, b1, lock_b;

    int errors;
    int checks;

    clk_wiz2 #(
        .CLKIN_FREQ  (50.0),
        .DIV0        (2),
        .DIV1        (4),
        .LOCK_CYCLES (64)
    ) dut (
        .clkin1   (clk_tb),
        .rst_n    (rst_n),
        .clkout0  (c0),
        .clkout1  (c1),
        .pll_lock (lock_a)
    );

    clk_wiz2 #(
        .CLKIN_FREQ  (50.0),
        .DIV0        (3),
        .DIV1        (6),
        .LOCK_CYCLES (64)
    ) dut_odd (
        .clkin1   (clk_tb),
        .rst_n    (rst_n),
        .clkout0  (b0),
        .clkout1  (b1),
        .pll_lock (lock_b)
    );

    initial clk_tb = 1'b0;
    always #10 clk_tb = ~clk_tb;

    // Timing monitors
    int      lock_rises = 0;
    int      lock_drops = 0;
    realtime lock_t     = 0.0;
    bit      first_pend = 1'b0;
    realtime first_dly  = 0.0;
    realtime c0_rise = 0.0, c0_per = 0.0, c0_high = 0.0;
    realtime c1_rise = 0.0, c1_per = 0.0, c1_high = 0.0;
    realtime b0_rise = 0.0, b0_per = 0.0, b0_high = 0.0;

    always @(posedge lock_a) begin
        lock_rises++;
        lock_t     = $realtime;
        first_pend = 1'b1;
    end

    always @(negedge lock_a) begin
        if (rst_n === 1'b1) lock_drops++;
    end

    always @(posedge c0) begin
        if (first_pend) begin
            first_dly  = $realtime - lock_t;
            first_pend = 1'b0;
        end
        c0_per  = $realtime - c0_rise;
        c0_rise = $realtime;
    end
    always @(negedge c0) c0_high = $realtime - c0_rise;

    always @(posedge c1) begin
        c1_per  = $realtime - c1_rise;
        c1_rise = $realtime;
    end
    always @(negedge c1) c1_high = $realtime - c1_rise;

    always @(posedge b0) begin
        b0_per  = $realtime - b0_rise;
        b0_rise = $realtime;
    end
    always @(negedge b0) b0_high = $realtime - b0_rise;

    // Edges 1..66 after reset release: lock only on edge 66, clocks idle.
    task automatic check_lock_window(input string tag);
        logic [5:0] got, exp;
        for (int n = 1; n <= 66; n++) begin
            @(posedge clk_tb);
            #1;
            got = {lock_a, c0, c1, lock_b, b0, b1};
            exp = {(n == 66), 1'b0, 1'b0, (n == 66), 1'b0, 1'b0};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL %s_lock edge %0d: got %b want %b", tag, n, got, exp);
            end
        end
    endtask

    // k-th edge after the lock edge: both channels start at cnt=0.
    task automatic check_divide(input string tag, input int cycles);
        logic [5:0] got, exp;
        for (int k = 0; k < cycles; k++) begin
            @(posedge clk_tb);
            #1;
            got = {lock_a, c0, c1, lock_b, b0, b1};
            exp = {1'b1, (k % 2 == 0), (k % 4 < 2), 1'b1, (k % 3 == 0), (k % 6 < 3)};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL %s_div cycle %0d: got %b want %b", tag, k, got, exp);
            end
        end
    endtask

    task automatic test_reset();
        #5;
        checks++;
        if ({lock_a, c0, c1, lock_b, b0, b1} !== 6'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b want 000000", {lock_a, c0, c1, lock_b, b0, b1});
        end
        #15;
        rst_n = 1'b1;
    endtask

    task automatic test_power_up();
        check_lock_window("power_up");
    endtask

    task automatic test_frequency();
        check_divide("freq", 40);
        checks++;
        if (c0_per != 40.0 || c0_high != 20.0) begin
            errors++;
            $display("FAIL clkout0_period: got per %0.1f high %0.1f want 40.0/20.0", c0_per, c0_high);
        end
        checks++;
        if (c1_per != 80.0 || c1_high != 40.0) begin
            errors++;
            $display("FAIL clkout1_period: got per %0.1f high %0.1f want 80.0/40.0", c1_per, c1_high);
        end
        checks++;
        if (b0_per != 60.0 || b0_high != 20.0) begin
            errors++;
            $display("FAIL odd_div_period: got per %0.1f high %0.1f want 60.0/20.0", b0_per, b0_high);
        end
        checks++;
        if (first_dly != 20.0) begin
            errors++;
            $display("FAIL first_rise_delay: got %0.1f want 20.0", first_dly);
        end
    endtask

    task automatic test_lock_stability();
        repeat (3000) @(posedge clk_tb);
        #1;
        checks++;
        if (lock_rises != 1 || lock_drops != 0 || lock_a !== 1'b1) begin
            errors++;
            $display("FAIL lock_stable: got rises %0d drops %0d lock %b want 1 0 1",
                     lock_rises, lock_drops, lock_a);
        end
    endtask

    task automatic test_mid_run_reset();
        @(posedge clk_tb);
        #5;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({lock_a, c0, c1, lock_b, b0, b1} !== 6'b0) begin
            errors++;
            $display("FAIL midrst_outputs: got %b want 000000", {lock_a, c0, c1, lock_b, b0, b1});
        end
        #29;
        rst_n = 1'b1;
        check_lock_window("relock");
        check_divide("relock", 12);
        checks++;
        if (lock_rises != 2 || lock_drops != 0) begin
            errors++;
            $display("FAIL relock_edges: got rises %0d drops %0d want 2 0", lock_rises, lock_drops);
        end
        checks++;
        if (first_dly != 20.0) begin
            errors++;
            $display("FAIL relock_first_rise: got %0.1f want 20.0", first_dly);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst_n  = 1'b0;
        test_reset();
        test_power_up();
        test_frequency();
        test_lock_stability();
        test_mid_run_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
